wb_sel_pipe: RTL

Parametrised, registered writeback result selector for the RISC-V datapath. Selects one of N_IN packed result sources (ALU, load data, PC+4, immediate, CSR, …) by a binary index and delivers it through a one-deep skid buffer with valid/ready handshakes, so the writeback stage can be split from execute without losing throughput. Out-of-range selects are flagged and forced to zero rather than driving X.

---
 rtl/wb_sel_pipe.sv | 138 +++++++++++++
 1 files changed

// File: rtl/wb_sel_pipe.sv
// wb_sel_pipe: registered writeback result selector with a one-deep skid buffer.
// Optional illegal-select counter enabled by defining WB_SEL_ERR_CNT_EN.
module wb_sel_pipe #(
    parameter int DATA_W    = 32,
    parameter int N_IN      = 3,
    parameter int SEL_W     = 2,
    parameter int ERR_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err_sticky,
    input  logic                   err_clr,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    logic [DATA_W-1:0] dec_data;
    logic              dec_err;

    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              main_err_q, main_err_d;
    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_err_q, skid_err_d;
    logic              skid_valid_q, skid_valid_d;
    logic              sticky_q, sticky_d;

    logic acc;
    logic drain;

    // in_ready depends only on the skid register, never on out_ready
    assign in_ready = ~skid_valid_q;
    assign acc      = in_valid & in_ready;
    assign drain    = main_valid_q & out_ready;

    // Decode select; out-of-range indices yield zero data with err set
    always_comb begin
        dec_data = '0;
        dec_err  = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                dec_data = in_data[k*DATA_W +: DATA_W];
                dec_err  = 1'b0;
            end
        end
    end

    // Next-state for main and skid registers
    always_comb begin
        main_data_d  = main_data_q;
        main_err_d   = main_err_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_err_d   = skid_err_q;
        skid_valid_d = skid_valid_q;
        if (acc && (!main_valid_q || drain)) begin
            main_data_d  = dec_data;
            main_err_d   = dec_err;
            main_valid_d = 1'b1;
        end else if (acc) begin
            skid_data_d  = dec_data;
            skid_err_d   = dec_err;
            skid_valid_d = 1'b1;
        end else if (drain && skid_valid_q) begin
            main_data_d  = skid_data_q;
            main_err_d   = skid_err_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    // Sticky error: a new illegal beat beats a simultaneous clear
    always_comb begin
        sticky_d = sticky_q;
        if (err_clr) sticky_d = 1'b0;
        if (acc && dec_err) sticky_d = 1'b1;
    end

    // Pipeline and sticky state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q  <= '0;
            main_err_q   <= 1'b0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_err_q   <= main_err_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_err_q   <= skid_err_d;
            skid_valid_q <= skid_valid_d;
            sticky_q     <= sticky_d;
        end
    end

    assign out_data   = main_data_q;
    assign out_err    = main_err_q;
    assign out_valid  = main_valid_q;
    assign err_sticky = sticky_q;

`ifdef WB_SEL_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    // Saturating illegal-beat counter; clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if (acc && dec_err && (cnt_q != {ERR_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign err_cnt = cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
